// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP responder.
package jtag_tap_pkg;

  localparam int unsigned IR_W     = 4;
  localparam int unsigned IDCODE_W = 32;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_W-1:0] INSTR_IDCODE  = 4'b0010;
  localparam logic [IR_W-1:0] INSTR_CONFREG = 4'b0111;
  localparam logic [IR_W-1:0] INSTR_USER    = 4'b0100;
  localparam logic [IR_W-1:0] INSTR_BYPASS  = 4'b1111;
  localparam logic [IR_W-1:0] IR_CAPTURE    = 4'b0101;

  // State decodes handed from the FSM to the register datapath.
  typedef struct packed {
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic enter_tlr;
    logic enter_upd_dr;
    logic enter_upd_ir;
  } tap_dec_t;

endpackage

// File: rtl/jtag_tap_if.sv
// Pad-side and SoC-side signals of the TAP responder.
interface jtag_tap_if #(
  parameter int unsigned CONF_W = 9
) ();
  logic              jtag_tms_i;
  logic              jtag_tdi_i;
  logic              jtag_tdo_o;
  logic [CONF_W-1:0] confreg_o;
  logic [CONF_W-1:0] confreg_i;
  logic              user_sel_o;
  logic              capture_dr_o;
  logic              shift_dr_o;
  logic              update_dr_o;
  logic              user_tdi_o;
  logic              user_tdo_i;

  modport master (
    output jtag_tms_i, jtag_tdi_i, confreg_i, user_tdo_i,
    input  jtag_tdo_o, confreg_o, user_sel_o, capture_dr_o, shift_dr_o,
           update_dr_o, user_tdi_o
  );

  modport slave (
    input  jtag_tms_i, jtag_tdi_i, confreg_i, user_tdo_i,
    output jtag_tdo_o, confreg_o, user_sel_o, capture_dr_o, shift_dr_o,
           update_dr_o, user_tdi_o
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller with state decodes for the datapath.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tms,
  output tap_dec_t dec_c
);

  tap_state_e state_q;
  tap_state_e state_next_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_next_c;
  end

  always_comb begin
    state_next_c = state_q;
    unique case (state_q)
      TLR:      state_next_c = tms ? TLR      : RTI;
      RTI:      state_next_c = tms ? SEL_DR   : RTI;
      SEL_DR:   state_next_c = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next_c = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_next_c = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_next_c = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next_c = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_next_c = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_next_c = tms ? SEL_DR   : RTI;
      SEL_IR:   state_next_c = tms ? TLR      : CAP_IR;
      CAP_IR:   state_next_c = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_next_c = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_next_c = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next_c = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_next_c = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_next_c = tms ? SEL_DR   : RTI;
      default:  state_next_c = TLR;
    endcase
  end

  // Update/TLR effects land on the edge that enters the state, hence next-state decodes.
  always_comb begin
    dec_c              = '0;
    dec_c.capture_dr   = (state_q == CAP_DR);
    dec_c.shift_dr     = (state_q == SH_DR);
    dec_c.update_dr    = (state_q == UPD_DR);
    dec_c.capture_ir   = (state_q == CAP_IR);
    dec_c.shift_ir     = (state_q == SH_IR);
    dec_c.enter_tlr    = (state_next_c == TLR);
    dec_c.enter_upd_dr = (state_next_c == UPD_DR);
    dec_c.enter_upd_ir = (state_next_c == UPD_IR);
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP responder: IR, BYPASS/IDCODE/CONFREG chains, USER hook, negedge TDO.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter logic [IDCODE_W-1:0] IDCODE_VAL = 32'h2495_11C3,
  parameter int unsigned         CONF_W     = 9
) (
  input  logic       jtag_tck_i,
  input  logic       jtag_trst_ni,
  jtag_tap_if.slave  tap
);

  tap_dec_t dec_c;

  logic [IR_W-1:0]     ir_q;
  logic [IR_W-1:0]     ir_shift_q;
  logic                bypass_q;
  logic [IDCODE_W-1:0] idcode_q;
  logic [CONF_W-1:0]   conf_shift_q;
  logic [CONF_W-1:0]   confreg_q;
  logic                tdo_q;
  logic                tdo_c;

  logic sel_idcode_c;
  logic sel_conf_c;
  logic sel_user_c;
  logic sel_bypass_c;

  jtag_tap_fsm u_fsm (
    .clk   (jtag_tck_i),
    .rst_n (jtag_trst_ni),
    .tms   (tap.jtag_tms_i),
    .dec_c (dec_c)
  );

  // Unlisted instruction codes fall through to BYPASS.
  always_comb begin
    sel_idcode_c = (ir_q == INSTR_IDCODE);
    sel_conf_c   = (ir_q == INSTR_CONFREG);
    sel_user_c   = (ir_q == INSTR_USER);
    sel_bypass_c = !(sel_idcode_c || sel_conf_c || sel_user_c);
  end

  // Instruction register path.
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      ir_q       <= INSTR_IDCODE;
      ir_shift_q <= '0;
    end else if (dec_c.enter_tlr) begin
      ir_q       <= INSTR_IDCODE;
      ir_shift_q <= '0;
    end else begin
      if (dec_c.capture_ir)    ir_shift_q <= IR_CAPTURE;
      else if (dec_c.shift_ir) ir_shift_q <= {tap.jtag_tdi_i, ir_shift_q[IR_W-1:1]};
      if (dec_c.enter_upd_ir)  ir_q <= ir_shift_q;
    end
  end

  // Data register chains; USER data lives outside this block.
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      bypass_q     <= 1'b0;
      idcode_q     <= '0;
      conf_shift_q <= '0;
      confreg_q    <= '0;
    end else if (dec_c.enter_tlr) begin
      bypass_q     <= 1'b0;
      idcode_q     <= '0;
      conf_shift_q <= '0;
      confreg_q    <= '0;
    end else begin
      if (dec_c.capture_dr) begin
        bypass_q <= 1'b0;
        if (sel_idcode_c) idcode_q     <= IDCODE_VAL;
        if (sel_conf_c)   conf_shift_q <= tap.confreg_i;
      end else if (dec_c.shift_dr) begin
        if (sel_bypass_c) bypass_q     <= tap.jtag_tdi_i;
        if (sel_idcode_c) idcode_q     <= {tap.jtag_tdi_i, idcode_q[IDCODE_W-1:1]};
        if (sel_conf_c)   conf_shift_q <= {tap.jtag_tdi_i, conf_shift_q[CONF_W-1:1]};
      end
      if (dec_c.enter_upd_dr && sel_conf_c) confreg_q <= conf_shift_q;
    end
  end

  always_comb begin
    tdo_c = 1'b0;
    if (dec_c.shift_ir) begin
      tdo_c = ir_shift_q[0];
    end else if (dec_c.shift_dr) begin
      if (sel_user_c)        tdo_c = tap.user_tdo_i;
      else if (sel_idcode_c) tdo_c = idcode_q[0];
      else if (sel_conf_c)   tdo_c = conf_shift_q[0];
      else                   tdo_c = bypass_q;
    end
  end

  // TDO launches on the falling edge so the initiator can sample it on the next rise.
  always_ff @(negedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) tdo_q <= 1'b0;
    else               tdo_q <= tdo_c;
  end

  assign tap.jtag_tdo_o   = tdo_q;
  assign tap.confreg_o    = confreg_q;
  assign tap.user_sel_o   = sel_user_c;
  assign tap.capture_dr_o = sel_user_c && dec_c.capture_dr;
  assign tap.shift_dr_o   = sel_user_c && dec_c.shift_dr;
  assign tap.update_dr_o  = sel_user_c && dec_c.update_dr;
  assign tap.user_tdi_o   = tap.jtag_tdi_i;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: IR capture, IDCODE, BYPASS, CONFREG, USER and trst abort.
module tb_jtag_tap_ctrl;
  import jtag_tap_pkg::*;

  localparam int unsigned CONF_W = 9;

  logic tck    = 1'b0;
  logic trst_n = 1'b1;
  int   tests  = 0;
  int   fails  = 0;
  logic tdo_s;

  int   cap_rises, shift_rises, upd_rises, shift_high;
  logic cap_prev, shift_prev, upd_prev;

  logic [3:0]  ir_out;
  logic [31:0] dr_out;

  always #5 tck = ~tck;

  jtag_tap_if #(.CONF_W(CONF_W)) tap_bus ();

  jtag_tap_ctrl #(.IDCODE_VAL(32'h2495_11C3), .CONF_W(CONF_W)) dut (
    .jtag_tck_i   (tck),
    .jtag_trst_ni (trst_n),
    .tap          (tap_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK: sample TDO, drive inputs after the falling edge, then track USER strobes.
  task automatic step(input logic tms, input logic tdi, input logic utdo);
    @(negedge tck); #1;
    tdo_s = tap_bus.jtag_tdo_o;
    tap_bus.jtag_tms_i = tms;
    tap_bus.jtag_tdi_i = tdi;
    tap_bus.user_tdo_i = utdo;
    @(posedge tck); #1;
    if (tap_bus.capture_dr_o && !cap_prev)   cap_rises++;
    if (tap_bus.shift_dr_o   && !shift_prev) shift_rises++;
    if (tap_bus.update_dr_o  && !upd_prev)   upd_rises++;
    if (tap_bus.shift_dr_o)                  shift_high++;
    cap_prev   = tap_bus.capture_dr_o;
    shift_prev = tap_bus.shift_dr_o;
    upd_prev   = tap_bus.update_dr_o;
  endtask

  // RTI -> IR scan -> RTI.
  task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, din[i], 1'b0);
      dout[i] = tdo_s;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // RTI -> DR scan of n bits -> RTI; upat is the external USER chain output.
  task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] upat,
                         output logic [31:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, upat[0]);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], (i + 1 < 32) ? upat[i+1] : 1'b0);
      dout[i] = tdo_s;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cap_rises = 0; shift_rises = 0; upd_rises = 0; shift_high = 0;
    cap_prev = 1'b0; shift_prev = 1'b0; upd_prev = 1'b0;
    tap_bus.jtag_tms_i = 1'b1;
    tap_bus.jtag_tdi_i = 1'b0;
    tap_bus.confreg_i  = '0;
    tap_bus.user_tdo_i = 1'b0;

    // Reset
    #2 trst_n = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    check("rst_state",    32'(dut.u_fsm.state_q), 32'(TLR));
    check("rst_tdo",      32'(tap_bus.jtag_tdo_o), 32'd0);
    check("rst_confreg",  32'(tap_bus.confreg_o), 32'd0);
    check("rst_user_sel", 32'(tap_bus.user_sel_o), 32'd0);
    @(negedge tck); #1 trst_n = 1'b1;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("tlr_after_5_tms", 32'(dut.u_fsm.state_q), 32'(TLR));
    check("tlr_ir",          32'(dut.ir_q), 32'(INSTR_IDCODE));
    check("tlr_strobes",     32'({tap_bus.capture_dr_o, tap_bus.shift_dr_o, tap_bus.update_dr_o}), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // IDCODE selected by reset
    scan_dr(32, 32'h0, 32'h0, dr_out);
    check("idcode", dr_out, 32'h2495_11C3);

    // BYPASS: one-bit delay with a leading 0
    scan_ir(INSTR_BYPASS, ir_out);
    check("ir_capture_bypass", 32'(ir_out), 32'h5);
    scan_dr(8, 32'hA5, 32'h0, dr_out);
    check("bypass_a5", dr_out, 32'h4A);

    // CONFREG write then readback of SoC status
    scan_ir(INSTR_CONFREG, ir_out);
    check("ir_capture_conf", 32'(ir_out), 32'h5);
    tap_bus.confreg_i = 9'h000;
    scan_dr(9, 32'h002, 32'h0, dr_out);
    check("conf_capture_0", dr_out, 32'h0);
    check("confreg_o_002",  32'(tap_bus.confreg_o), 32'h002);
    tap_bus.confreg_i = 9'h155;
    scan_dr(9, 32'h0AA, 32'h0, dr_out);
    check("conf_capture_155", dr_out, 32'h155);
    check("confreg_o_0aa",    32'(tap_bus.confreg_o), 32'h0AA);

    // Unlisted instruction behaves as BYPASS and leaves confreg alone
    scan_ir(4'b1010, ir_out);
    scan_dr(4, 32'hB, 32'h0, dr_out);
    check("unknown_ir_bypass", dr_out, 32'h6);
    check("unknown_ir_conf",   32'(tap_bus.confreg_o), 32'h0AA);

    // USER hook
    scan_ir(INSTR_USER, ir_out);
    check("user_sel", 32'(tap_bus.user_sel_o), 32'd1);
    cap_rises = 0; shift_rises = 0; upd_rises = 0; shift_high = 0;
    scan_dr(8, 32'h5A, 32'h3C, dr_out);
    check("user_tdo",         dr_out, 32'h3C);
    check("user_cap_pulses",  32'(cap_rises), 32'd1);
    check("user_shift_pulse", 32'(shift_rises), 32'd1);
    check("user_shift_len",   32'(shift_high), 32'd8);
    check("user_upd_pulses",  32'(upd_rises), 32'd1);
    tap_bus.jtag_tdi_i = 1'b1; #1;
    check("user_tdi_1", 32'(tap_bus.user_tdi_o), 32'd1);
    tap_bus.jtag_tdi_i = 1'b0; #1;
    check("user_tdi_0", 32'(tap_bus.user_tdi_o), 32'd0);

    // Five TMS=1 from Shift-DR reach TLR and restore IDCODE
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("user_shift_strobe", 32'(tap_bus.shift_dr_o), 32'd1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("tlr_from_shdr",     32'(dut.u_fsm.state_q), 32'(TLR));
    check("tlr_user_sel_clr",  32'(tap_bus.user_sel_o), 32'd0);
    check("tlr_confreg_clr",   32'(tap_bus.confreg_o), 32'd0);

    // trst during CONFREG shift aborts without update
    step(1'b0, 1'b0, 1'b0);
    scan_ir(INSTR_CONFREG, ir_out);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    #2 trst_n = 1'b0;
    #1;
    check("abort_state",   32'(dut.u_fsm.state_q), 32'(TLR));
    check("abort_confreg", 32'(tap_bus.confreg_o), 32'd0);
    check("abort_ir",      32'(dut.ir_q), 32'(INSTR_IDCODE));
    check("abort_tdo",     32'(tap_bus.jtag_tdo_o), 32'd0);
    tap_bus.jtag_tms_i = 1'b0;
    @(negedge tck); #1 trst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    scan_dr(32, 32'h0, 32'h0, dr_out);
    check("idcode_after_abort", dr_out, 32'h2495_11C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
